// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_pkg
// Shared definitions for the ALU issue sequencer: op-code values, the 2-bit
// function-class encoding reported alongside each result, the sequencer FSM
// states, and small decode helpers used by both the result mux and the
// shift-step datapath.
// -----------------------------------------------------------------------------
package alu_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_LUI = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        FN_LUI   = 2'b00,
        FN_SHIFT = 2'b01,
        FN_ARITH = 2'b10,
        FN_LOGIC = 2'b11
    } fn_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True for the three ops that iterate one bit per cycle.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Illegal op codes (10-15) report the logic class.
    function automatic fn_class_e fn_class_of(input logic [3:0] op);
        fn_class_e fc;
        case (op)
            OP_LUI:                 fc = FN_LUI;
            OP_SLL, OP_SRL, OP_SRA: fc = FN_SHIFT;
            OP_ADD, OP_SUB:         fc = FN_ARITH;
            default:                fc = FN_LOGIC;
        endcase
        return fc;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Issue/result handshake bundle for the ALU sequencer.
//   Issue side : in_valid, in_ready, op[3:0], a, b
//   Result side: out_valid, out_ready, result, fn_class[1:0],
//                out_carry, out_zero, out_err
// master = issuing/consuming agent, slave = the sequencer.
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [1:0]       fn_class;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, fn_class, out_carry, out_zero, out_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, fn_class, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/alu_shift_step.sv
// -----------------------------------------------------------------------------
// alu_shift_step
// Combinational single-bit shift of a WIDTH-bit word.
//   op   in  4      OP_SLL (zero-fill), OP_SRL (zero-fill), OP_SRA (sign-fill);
//                   any other code passes din through unchanged
//   din  in  WIDTH  value to shift
//   dout out WIDTH  value shifted by one bit
// -----------------------------------------------------------------------------
module alu_shift_step
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // One bit per call; the sequencer invokes this once per SHIFT cycle.
    always_comb begin
        dout = din;
        case (op)
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Issue-side sequencer for the ALU datapath. Accepts one op per valid/ready
// handshake, computes single-cycle ops immediately, iterates shifts one bit per
// cycle, and holds the registered result until the consumer takes it.
//   clk  in   single clock, all state changes on posedge
//   rst  in   synchronous active-high reset
//   bus  slave modport of alu_seq_ctrl_if (issue + result handshakes)
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);

    state_e             state;
    state_e             next_state;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt_in;
    logic [3:0]         shift_op;
    logic [WIDTH-1:0]   shift_val;
    logic [WIDTH-1:0]   shift_next;
    logic               accept;
    logic               start_shift;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   calc_result;
    logic               calc_carry;
    logic               calc_err;
    logic [WIDTH-1:0]   result_q;
    fn_class_e          fn_class_q;
    logic               carry_q;
    logic               zero_q;
    logic               err_q;

    // A new op is taken when idle, or when the held result is being consumed
    // in the same cycle, which gives back-to-back issue with no bubble.
    assign shamt_in    = bus.b[SHAMT_W-1:0];
    assign bus.in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept      = bus.in_valid && bus.in_ready;
    assign start_shift = is_shift_op(bus.op) && (shamt_in != '0);

    alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .op   (shift_op),
        .din  (shift_val),
        .dout (shift_next)
    );

    // Single-cycle result mux. A shift by zero lands here too and simply
    // returns operand A; illegal codes produce zero with the error flag.
    always_comb begin
        sum_ext     = '0;
        calc_result = '0;
        calc_carry  = 1'b0;
        calc_err    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sum_ext     = {1'b0, bus.a} + {1'b0, bus.b};
                calc_result = sum_ext[WIDTH-1:0];
                calc_carry  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                calc_result = bus.a - bus.b;
                calc_carry  = (bus.a < bus.b);
            end
            OP_AND:                 calc_result = bus.a & bus.b;
            OP_OR:                  calc_result = bus.a | bus.b;
            OP_XOR:                 calc_result = bus.a ^ bus.b;
            OP_NOT:                 calc_result = ~bus.a;
            OP_SLL, OP_SRL, OP_SRA: calc_result = bus.a;
            OP_LUI:                 calc_result = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:                calc_err    = 1'b1;
        endcase
    end

    // Next-state decode. An accept overrides whatever the current state would
    // otherwise do; SHIFT leaves on the last remaining bit.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = ST_IDLE;
            ST_SHIFT: if (cnt == SHAMT_W'(1)) next_state = ST_DONE;
            ST_DONE:  if (bus.out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (accept) begin
            next_state = start_shift ? ST_SHIFT : ST_DONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: operand latch and bit counter for shifts, plus the
    // held result and flags. The result registers only change on completion,
    // so they stay stable through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            shift_op   <= '0;
            shift_val  <= '0;
            result_q   <= '0;
            fn_class_q <= FN_LUI;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                shift_val <= bus.a;
                shift_op  <= bus.op;
                cnt       <= shamt_in;
            end else begin
                result_q   <= calc_result;
                fn_class_q <= fn_class_of(bus.op);
                carry_q    <= calc_carry;
                zero_q     <= (calc_result == '0);
                err_q      <= calc_err;
            end
        end else if (state == ST_SHIFT) begin
            shift_val <= shift_next;
            cnt       <= cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
                result_q   <= shift_next;
                fn_class_q <= FN_SHIFT;
                carry_q    <= 1'b0;
                zero_q     <= (shift_next == '0);
                err_q      <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.fn_class  = fn_class_q;
    assign bus.out_carry = carry_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. Each issued op has its expected result,
// flags, class and latency computed by a reference model and queued; the
// entry is popped and compared when the sequencer raises out_valid.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int BUDGET  = 64;

    typedef struct {
        logic [31:0] result;
        logic [1:0]  fn_class;
        logic        carry;
        logic        zero;
        logic        err;
        int          latency;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    exp_t   sb_q[$];
    string  tag_q[$];
    int     test_count = 0;
    int     fail_count = 0;

    alu_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference model written directly from the op definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        int          sh;
        sh         = int'(b[4:0]);
        e.result   = 32'h0;
        e.carry    = 1'b0;
        e.err      = 1'b0;
        e.latency  = 1;
        e.fn_class = 2'b11;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.result = s[31:0]; e.carry = s[32]; e.fn_class = 2'b10; end
            4'd1: begin e.result = a - b; e.carry = (a < b); e.fn_class = 2'b10; end
            4'd2: e.result = a & b;
            4'd3: e.result = a | b;
            4'd4: e.result = a ^ b;
            4'd5: e.result = ~a;
            4'd6: begin e.result = a << sh; e.fn_class = 2'b01; e.latency = sh + 1; end
            4'd7: begin e.result = a >> sh; e.fn_class = 2'b01; e.latency = sh + 1; end
            4'd8: begin e.result = $unsigned($signed(a) >>> sh); e.fn_class = 2'b01; e.latency = sh + 1; end
            4'd9: begin e.result = {b[15:0], 16'h0000}; e.fn_class = 2'b00; end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one op and hold it until accepted; optionally queue its expectation.
    // Operands are scrambled after accept since the DUT must not need them held.
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input string tag, input bit track);
        int guard = 0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        #1;
        while (bus.in_ready !== 1'b1 && guard < BUDGET) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= BUDGET) begin
            test_count++;
            fail_count++;
            $display("[TB] FAIL %s accept timeout: in_ready %b required 1", tag, bus.in_ready);
        end
        if (track) begin
            sb_q.push_back(model(op, a, b));
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom_range(0, 15));
        bus.a        = $urandom();
        bus.b        = $urandom();
    endtask

    // Called right after apply_stimulus returns; measures latency from accept.
    task automatic check_output();
        exp_t  e;
        string tag;
        int    waited = 1;
        if (sb_q.size() == 0) begin
            test_count++;
            fail_count++;
            $display("[TB] FAIL scoreboard empty: queue size 0 required >0");
            return;
        end
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        while (bus.out_valid !== 1'b1 && waited < BUDGET) begin
            @(posedge clk);
            #1;
            waited++;
        end
        compare({tag, " latency"},  32'(waited), 32'(e.latency));
        compare({tag, " result"},   bus.result, e.result);
        compare({tag, " fn_class"}, 32'(bus.fn_class), 32'(e.fn_class));
        compare({tag, " carry"},    32'(bus.out_carry), 32'(e.carry));
        compare({tag, " zero"},     32'(bus.out_zero), 32'(e.zero));
        compare({tag, " err"},      32'(bus.out_err), 32'(e.err));
    endtask

    // Directed sequence: reset values, each op family, shift boundaries,
    // backpressure with same-cycle handoff, mid-shift reset, illegal op.
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 4'h0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare("reset out_valid", 32'(bus.out_valid), 32'h0);
        compare("reset result",    bus.result, 32'h0);
        compare("reset fn_class",  32'(bus.fn_class), 32'h0);
        compare("reset carry",     32'(bus.out_carry), 32'h0);
        compare("reset zero",      32'(bus.out_zero), 32'h0);
        compare("reset err",       32'(bus.out_err), 32'h0);
        compare("reset in_ready",  32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        compare("post-reset in_ready", 32'(bus.in_ready), 32'h1);

        apply_stimulus(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap", 1'b1); check_output();
        apply_stimulus(4'd8, 32'h8000_0000, 32'h0000_0004, "sra4",     1'b1); check_output();
        apply_stimulus(4'd6, 32'h1234_5678, 32'h0000_0000, "sll0",     1'b1); check_output();
        apply_stimulus(4'd7, 32'hF000_0001, 32'h0000_0021, "srl1",     1'b1); check_output();
        apply_stimulus(4'd6, 32'h0000_0001, 32'h0000_001F, "sll31",    1'b1); check_output();
        apply_stimulus(4'd9, 32'hDEAD_BEEF, 32'h0000_1234, "lui",      1'b1); check_output();
        apply_stimulus(4'd1, 32'h0000_0003, 32'h0000_0005, "sub_brw",  1'b1); check_output();
        apply_stimulus(4'd1, 32'h0000_0005, 32'h0000_0005, "sub_zero", 1'b1); check_output();
        apply_stimulus(4'd3, 32'hA500_00F0, 32'h005A_0F00, "or",       1'b1); check_output();
        apply_stimulus(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, "xor",      1'b1); check_output();
        apply_stimulus(4'd5, 32'h0F0F_0F0F, 32'hFFFF_FFFF, "not",      1'b1); check_output();

        apply_stimulus(4'd0, 32'h0000_0001, 32'h0000_0002, "bp_add",   1'b1);
        bus.out_ready = 1'b0;
        check_output();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compare("bp hold out_valid", 32'(bus.out_valid), 32'h1);
            compare("bp hold result",    bus.result, 32'h0000_0003);
            compare("bp hold fn_class",  32'(bus.fn_class), 32'h2);
            compare("bp hold in_ready",  32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        apply_stimulus(4'd2, 32'h0000_F0F0, 32'h0000_FF00, "bp_and",   1'b1); check_output();

        apply_stimulus(4'd6, 32'h0000_0001, 32'h0000_000A, "rst_shift", 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        compare("mid-shift out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b1;
        #1;
        compare("rst in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        compare("after rst out_valid", 32'(bus.out_valid), 32'h0);
        compare("after rst in_ready",  32'(bus.in_ready), 32'h1);
        compare("after rst result",    bus.result, 32'h0);

        apply_stimulus(4'hF, 32'h0000_0005, 32'h0000_0007, "illegal",  1'b1); check_output();
        apply_stimulus(4'd0, 32'h0000_0002, 32'h0000_0002, "legal",    1'b1); check_output();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
